// File: rtl/dmrs_slot_scheduler_pkg.sv
// Shared constants and state encoding for the NB-IoT NPUSCH format-1 slot scheduler.
package dmrs_slot_scheduler_pkg;

    localparam int unsigned NSC         = 12;
    localparam int unsigned SYMS        = 7;
    localparam int unsigned DMRS_SYM    = 3;
    localparam int unsigned SLOT_W      = 5;
    localparam int unsigned SC_W        = 4;
    localparam int unsigned SYM_W       = 3;
    localparam int unsigned ADDR_W      = SC_W + 1;
    localparam int unsigned RE_PER_SLOT = NSC * SYMS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmrs_slot_scheduler_grid_re_counter.sv
// Cascaded subcarrier/symbol/slot counter; last_o flags the final RE of the burst.
module dmrs_slot_scheduler_grid_re_counter
    import dmrs_slot_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [SLOT_W-1:0] slot_lim_i,
    output logic [SC_W-1:0]   sc_o,
    output logic [SYM_W-1:0]  sym_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              last_o
);

    logic [SC_W-1:0]   sc_q,   sc_d;
    logic [SYM_W-1:0]  sym_q,  sym_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              sc_last, sym_last, slot_last;

    assign sc_last   = (sc_q == SC_W'(NSC - 1));
    assign sym_last  = (sym_q == SYM_W'(SYMS - 1));
    assign slot_last = (slot_q == slot_lim_i - SLOT_W'(1));
    assign last_o    = sc_last && sym_last && slot_last;

    // NOTE: every always_comb output gets its hold value first so no path infers a latch.
    always_comb begin
        sc_d   = sc_q;
        sym_d  = sym_q;
        slot_d = slot_q;
        if (clr_i) begin
            sc_d   = '0;
            sym_d  = '0;
            slot_d = '0;
        end else if (en_i) begin
            if (sc_last) begin
                sc_d = '0;
                if (sym_last) begin
                    sym_d  = '0;
                    slot_d = slot_last ? '0 : slot_q + SLOT_W'(1);
                end else begin
                    sym_d = sym_q + SYM_W'(1);
                end
            end else begin
                sc_d = sc_q + SC_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q   <= '0;
            sym_q  <= '0;
            slot_q <= '0;
        end else begin
            sc_q   <= sc_d;
            sym_q  <= sym_d;
            slot_q <= slot_d;
        end
    end

    assign sc_o   = sc_q;
    assign sym_o  = sym_q;
    assign slot_o = slot_q;

endmodule

// File: rtl/dmrs_slot_scheduler.sv
// Burst FSM and RE handshake: interleaves DMRS bank reads with PUSCH data on the grid stream.
module dmrs_slot_scheduler
    import dmrs_slot_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [SLOT_W-1:0] num_slots_i,
    input  logic              abort_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              re_valid_o,
    input  logic              re_ready_i,
    output logic              sel_dmrs_o,
    output logic [ADDR_W-1:0] dmrs_addr_o,
    output logic [SC_W-1:0]   sc_idx_o,
    output logic [SYM_W-1:0]  sym_idx_o,
    output logic [SLOT_W-1:0] slot_idx_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] num_slots_q, num_slots_d;
    logic              run, hs, cnt_clr, cnt_en, cnt_last;

    dmrs_slot_scheduler_grid_re_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .slot_lim_i (num_slots_q),
        .sc_o       (sc_idx_o),
        .sym_o      (sym_idx_o),
        .slot_o     (slot_idx_o),
        .last_o     (cnt_last)
    );

    assign run          = (state_q == ST_RUN);
    assign sel_dmrs_o   = run && (sym_idx_o == SYM_W'(DMRS_SYM));
    assign re_valid_o   = run && (sel_dmrs_o || data_valid_i);
    assign data_ready_o = re_ready_i && run && !sel_dmrs_o;
    assign hs           = re_valid_o && re_ready_i;
    // Abort wins over a completing handshake, so the counters never step on that edge.
    assign cnt_en       = hs && !abort_i;
    assign dmrs_addr_o  = {slot_idx_o[0], sc_idx_o};
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);

    always_comb begin
        state_d     = state_q;
        num_slots_d = num_slots_q;
        cnt_clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && (num_slots_i != '0)) begin
                    state_d     = ST_RUN;
                    num_slots_d = num_slots_i;
                    cnt_clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (hs && cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_clr = abort_i;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_slots_q <= '0;
        end else begin
            state_q     <= state_d;
            num_slots_q <= num_slots_d;
        end
    end

endmodule

// File: tb/tb_dmrs_slot_scheduler.sv
// Randomized and directed bench for dmrs_slot_scheduler against a per-RE index model.
module tb_dmrs_slot_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] num_slots = '0;
    logic       abort = 1'b0;
    logic       data_valid = 1'b0;
    logic       re_ready = 1'b0;
    logic       data_ready, re_valid, sel_dmrs, busy, done;
    logic [4:0] dmrs_addr, slot_idx;
    logic [3:0] sc_idx;
    logic [2:0] sym_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: burst phase (0 idle, 1 run, 2 done), REs accepted so far, burst length.
    int m_state = 0;
    int m_n     = 0;
    int m_ns    = 0;

    logic obs_done, obs_hs;

    always #5 clk = ~clk;

    dmrs_slot_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .num_slots_i  (num_slots),
        .abort_i      (abort),
        .data_valid_i (data_valid),
        .data_ready_o (data_ready),
        .re_valid_o   (re_valid),
        .re_ready_i   (re_ready),
        .sel_dmrs_o   (sel_dmrs),
        .dmrs_addr_o  (dmrs_addr),
        .sc_idx_o     (sc_idx),
        .sym_idx_o    (sym_idx),
        .slot_idx_o   (slot_idx),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        bit run, sel;
        int sc, sym, slot;
        run  = (m_state == 1);
        sc   = m_n % 12;
        sym  = (m_n / 12) % 7;
        slot = m_n / 84;
        sel  = run && (sym == 3);
        check("busy",       32'(busy),       int'(m_state != 0));
        check("done",       32'(done),       int'(m_state == 2));
        check("sel_dmrs",   32'(sel_dmrs),   int'(sel));
        check("re_valid",   32'(re_valid),   int'(run && (sel || data_valid)));
        check("data_ready", 32'(data_ready), int'(run && re_ready && !sel));
        check("sc_idx",     32'(sc_idx),     sc);
        check("sym_idx",    32'(sym_idx),    sym);
        check("slot_idx",   32'(slot_idx),   slot);
        check("dmrs_addr",  32'(dmrs_addr),  (slot % 2) * 16 + sc);
    endtask

    task automatic model_step();
        bit sel;
        sel = (m_state == 1) && (((m_n / 12) % 7) == 3);
        case (m_state)
            0: if (start && num_slots != 0) begin
                m_state = 1;
                m_n     = 0;
                m_ns    = int'(num_slots);
            end
            1: if (abort) begin
                m_state = 0;
                m_n     = 0;
            end else if ((sel || data_valid) && re_ready) begin
                m_n++;
                if (m_n == m_ns * 84) begin
                    m_state = 2;
                    m_n     = 0;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic cycle(input bit st, input int ns, input bit ab, input bit dv, input bit rr);
        @(negedge clk);
        start      = st;
        num_slots  = ns[4:0];
        abort      = ab;
        data_valid = dv;
        re_ready   = rr;
        #1;
        check_outputs();
        obs_done = done;
        obs_hs   = re_valid && re_ready;
        @(posedge clk);
        model_step();
    endtask

    task automatic drain(input bit dv, input bit rr);
        int guard = 0;
        while (m_state != 0 && guard < 3000) begin
            cycle(0, 0, 0, dv, rr);
            guard++;
        end
        check("drain_timeout", 32'(guard < 3000), 1);
    endtask

    initial begin
        int lat, hs_cnt, guard;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Two-slot burst, continuous flow: done must land 169 cycles after the start edge
        cycle(1, 2, 0, 1, 1);
        lat = 0;
        for (int i = 1; i <= 400; i++) begin
            cycle(0, 2, 0, 1, 1);
            if (obs_done) begin
                lat = i;
                break;
            end
        end
        check("done_latency", lat, 169);
        cycle(0, 0, 0, 1, 1);

        // num_slots=0 start is ignored
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 1);

        // Data starvation: stalls at RE 0, DMRS symbol passes with no data, stalls again at symbol 4
        cycle(1, 1, 0, 0, 1);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1);
        guard = 0;
        while (m_n < 36 && guard < 200) begin
            cycle(0, 0, 0, 1, 1);
            guard++;
        end
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1);
        check("stall_sym", 32'(sym_idx), 4);
        check("stall_sc",  32'(sc_idx),  0);
        drain(1, 1);

        // re_ready toggling on a 3-slot burst, with stray start pulses that must be ignored
        cycle(1, 3, 0, 1, 0);
        hs_cnt = 0;
        for (int i = 0; i < 520 && m_state == 1; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 31), 0, 1, (i % 2) == 0);
            if (obs_hs) hs_cnt++;
        end
        check("toggle_handshakes", hs_cnt, 252);
        drain(1, 1);

        // Abort at handshake 50 (a handshake is presented on the abort cycle too), then a clean rerun
        cycle(1, 2, 0, 1, 1);
        guard = 0;
        while (m_n < 50 && guard < 200) begin
            cycle(0, 0, 0, 1, 1);
            guard++;
        end
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(1, 2, 0, 1, 1);
        drain(1, 1);

        // Randomized traffic with random bursts, stalls and rare aborts
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        drain(1, 1);

        // Asynchronous reset at slot 1 symbol 5: outputs clear without a clock edge
        cycle(1, 2, 0, 1, 1);
        guard = 0;
        while (m_n < 144 && guard < 300) begin
            cycle(0, 0, 0, 1, 1);
            guard++;
        end
        check("pre_rst_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        m_state = 0;
        m_n     = 0;
        check("rst_busy",       32'(busy),       0);
        check("rst_done",       32'(done),       0);
        check("rst_re_valid",   32'(re_valid),   0);
        check("rst_data_ready", 32'(data_ready), 0);
        check("rst_sel_dmrs",   32'(sel_dmrs),   0);
        check("rst_dmrs_addr",  32'(dmrs_addr),  0);
        check("rst_sc_idx",     32'(sc_idx),     0);
        check("rst_sym_idx",    32'(sym_idx),    0);
        check("rst_slot_idx",   32'(slot_idx),   0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 1, 0, 1, 1);
        drain(1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
